// File: rtl/regfile_read_ports.sv
// Eight-entry register file with two registered read ports and a dedicated PC (R7) write path.
// Reads sample the post-write register image, so same-edge writes bypass into the read data.
module regfile_read_ports #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_write,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              rd_req_a,
  input  logic              rd_req_b,
  input  logic [2:0]        rd_addr_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b,
  output logic [DATA_W-1:0] pc_out
);

  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] PC_ADDR = AW'(7);

  logic [DATA_W-1:0] regs     [NREG];
  logic [DATA_W-1:0] regs_nxt [NREG];

  // General write is applied after the PC write so it wins on R7
  always_comb begin
    regs_nxt = regs;
    if (!pc_write) regs_nxt[PC_ADDR] = pc_in;
    if (!write)    regs_nxt[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs       <= '{default: '0};
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
    end else begin
      regs       <= regs_nxt;
      rd_valid_a <= rd_req_a;
      rd_valid_b <= rd_req_b;
      if (rd_req_a) rd_data_a <= regs_nxt[rd_addr_a];
      if (rd_req_b) rd_data_b <= regs_nxt[rd_addr_b];
    end
  end

  assign pc_out = regs[PC_ADDR];

endmodule

// File: tb/tb_regfile_read_ports.sv
// Directed test of regfile_read_ports: writes, bypass, R7 priority, dual-port reads, reset.
module tb_regfile_read_ports;

  logic        clk;
  logic        reset;
  logic        write;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pc_write;
  logic [15:0] pc_in;
  logic        rd_req_a, rd_req_b;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [15:0] pc_out;

  int tests = 0;
  int fails = 0;

  regfile_read_ports #(.DATA_W(16), .NREG(8)) dut (
    .clk(clk), .reset(reset), .write(write), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_write(pc_write), .pc_in(pc_in),
    .rd_req_a(rd_req_a), .rd_req_b(rd_req_b), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; write = 1'b1; pc_write = 1'b1;
    rd_req_a = 1'b0; rd_req_b = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    wr_addr = '0; wr_data = '0; pc_in = '0; rd_addr_a = '0; rd_addr_b = '0;

    // Reset state
    reset = 1'b0;
    tick();
    check("rst_data_a", rd_data_a, 16'h0);
    check("rst_data_b", rd_data_b, 16'h0);
    check("rst_valid_a", 16'(rd_valid_a), 16'h0);
    check("rst_valid_b", 16'(rd_valid_b), 16'h0);
    check("rst_pc_out", pc_out, 16'h0);
    idle();

    // Write then read with one-cycle latency
    write = 1'b0; wr_addr = 3'd3; wr_data = 16'hBEEF;
    tick();
    idle();
    rd_req_a = 1'b1; rd_addr_a = 3'd3;
    tick();
    check("rd3_data_a", rd_data_a, 16'hBEEF);
    check("rd3_valid_a", 16'(rd_valid_a), 16'h1);
    idle();
    tick();
    check("rd3_valid_drop", 16'(rd_valid_a), 16'h0);
    check("rd3_data_hold", rd_data_a, 16'hBEEF);

    // Same-edge write/read bypass on port B
    write = 1'b0; wr_addr = 3'd5; wr_data = 16'h1234;
    rd_req_b = 1'b1; rd_addr_b = 3'd5;
    tick();
    check("byp5_data_b", rd_data_b, 16'h1234);
    check("byp5_valid_b", 16'(rd_valid_b), 16'h1);
    idle();

    // General write beats PC write on R7, also seen through bypass
    write = 1'b0; wr_addr = 3'd7; wr_data = 16'h00AA;
    pc_write = 1'b0; pc_in = 16'h0055;
    rd_req_a = 1'b1; rd_addr_a = 3'd7;
    tick();
    check("r7_prio_pc_out", pc_out, 16'h00AA);
    check("r7_prio_byp_a", rd_data_a, 16'h00AA);
    idle();

    // PC write then dual-port read of R7 and R2
    write = 1'b0; wr_addr = 3'd2; wr_data = 16'h0002;
    tick();
    idle();
    pc_write = 1'b0; pc_in = 16'h0010;
    tick();
    check("pcw_pc_out", pc_out, 16'h0010);
    idle();
    rd_req_a = 1'b1; rd_addr_a = 3'd7;
    rd_req_b = 1'b1; rd_addr_b = 3'd2;
    tick();
    check("dual_data_a", rd_data_a, 16'h0010);
    check("dual_data_b", rd_data_b, 16'h0002);
    check("dual_valid_a", 16'(rd_valid_a), 16'h1);
    check("dual_valid_b", 16'(rd_valid_b), 16'h1);
    idle();

    // PC-only write bypass, and both ports on the same address
    pc_write = 1'b0; pc_in = 16'h0077;
    rd_req_a = 1'b1; rd_addr_a = 3'd7;
    rd_req_b = 1'b1; rd_addr_b = 3'd7;
    tick();
    check("pcbyp_data_a", rd_data_a, 16'h0077);
    check("pcbyp_data_b", rd_data_b, 16'h0077);
    idle();

    // Streaming reads of R0..R3
    for (int i = 0; i < 4; i++) begin
      write = 1'b0; wr_addr = 3'(i); wr_data = 16'hA000 + 16'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_req_a = 1'b1; rd_addr_a = 3'(i);
      tick();
      check($sformatf("stream_valid_%0d", i), 16'(rd_valid_a), 16'h1);
      check($sformatf("stream_data_%0d", i), rd_data_a, 16'hA000 + 16'(i));
    end
    idle();
    tick();
    check("stream_valid_end", 16'(rd_valid_a), 16'h0);

    // Load all registers, read, then reset with pending traffic
    for (int i = 0; i < 8; i++) begin
      write = 1'b0; wr_addr = 3'(i); wr_data = 16'h1000 + 16'(i * 16'h0111);
      tick();
    end
    idle();
    rd_req_a = 1'b1; rd_addr_a = 3'd4;
    tick();
    check("pre_rst_data_a", rd_data_a, 16'h1444);
    check("pre_rst_valid_a", 16'(rd_valid_a), 16'h1);
    reset = 1'b0;
    write = 1'b0; wr_addr = 3'd1; wr_data = 16'hFFFF;
    pc_write = 1'b0; pc_in = 16'hEEEE;
    rd_req_b = 1'b1; rd_addr_b = 3'd6;
    tick();
    check("rst2_data_a", rd_data_a, 16'h0);
    check("rst2_data_b", rd_data_b, 16'h0);
    check("rst2_valid_a", 16'(rd_valid_a), 16'h0);
    check("rst2_valid_b", 16'(rd_valid_b), 16'h0);
    check("rst2_pc_out", pc_out, 16'h0);
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_req_a = 1'b1; rd_addr_a = 3'(i);
      rd_req_b = 1'b1; rd_addr_b = 3'(7 - i);
      tick();
      check($sformatf("post_rst_a_%0d", i), rd_data_a, 16'h0);
      check($sformatf("post_rst_b_%0d", 7 - i), rd_data_b, 16'h0);
      check($sformatf("post_rst_valid_%0d", i), 16'(rd_valid_a), 16'h1);
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_read_ports.md
REGFILE_READ_PORTS -- requirements
Module: regfile_read_ports

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register and data width in bits.
REQ-002 The block SHALL have parameter NREG, default 8, meaning number of registers; the address width is 3 bits.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port write, input, 1, active-low general write enable.
REQ-006 The block SHALL have port wr_addr, input, 3, write address.
REQ-007 The block SHALL have port wr_data, input, DATA_W, write data.
REQ-008 The block SHALL have port pc_write, input, 1, active-low dedicated R7 (PC) write enable.
REQ-009 The block SHALL have port pc_in, input, DATA_W, PC write data.
REQ-010 The block SHALL have ports rd_req_a and rd_req_b, input, 1 each, active-high read requests for ports A and B.
REQ-011 The block SHALL have ports rd_addr_a and rd_addr_b, input, 3 each, read addresses.
REQ-012 The block SHALL have ports rd_data_a and rd_data_b, output, DATA_W each, registered read data.
REQ-013 The block SHALL have ports rd_valid_a and rd_valid_b, output, 1 each, read data valid strobes.
REQ-014 The block SHALL have port pc_out, output, DATA_W, current R7 contents, combinational from R7 storage.

Function
REQ-015 The block SHALL hold NREG registers R0..R7 of DATA_W bits each; R0 is an ordinary writable register.
REQ-016 On a posedge with reset=1 and write=0, the block SHALL load wr_data into R[wr_addr].
REQ-017 On a posedge with reset=1 and pc_write=0, the block SHALL load pc_in into R7.
REQ-018 When write=0, wr_addr=7 and pc_write=0 on the same edge, the block SHALL load wr_data into R7 (general write wins) and SHALL discard pc_in.
REQ-019 Read latency SHALL be one cycle: a read request sampled high at edge N SHALL drive rd_data_x with the register value and rd_valid_x=1 after edge N.
REQ-020 rd_valid_x SHALL be 1 for exactly one cycle per sampled request; back-to-back requests SHALL produce back-to-back valid cycles.
REQ-021 When rd_req_x=0 at an edge, the block SHALL drive rd_valid_x=0 after that edge and SHALL hold rd_data_x unchanged.
REQ-022 Bypass: when a read at edge N addresses a register that is written at the same edge N, rd_data_x SHALL return the newly written value, using the REQ-018 priority for R7.
REQ-023 Ports A and B SHALL be independent; both ports SHALL be able to read the same address at the same edge with identical results.
REQ-024 pc_out SHALL reflect an R7 update in the cycle after the writing edge.
REQ-025 Out-of-order interaction SHALL NOT exist: every read returns state as of its sampling edge plus the same-edge writes only.

Reset
REQ-026 On a posedge with reset=0, the block SHALL clear R0..R7, rd_data_a, rd_data_b, rd_valid_a and rd_valid_b to 0, so pc_out=0.
REQ-027 Reset SHALL dominate: write, pc_write and rd_req_x sampled at a reset edge SHALL be ignored and SHALL NOT produce a valid strobe.
REQ-028 A read requested at the edge before reset asserts SHALL have its valid output cleared by the reset edge.
REQ-029 Before the first reset edge, outputs are unspecified; the bench SHALL NOT check them.

Verification
REQ-030 The bench SHALL drive write=0, wr_addr=3, wr_data=16'hBEEF for one edge, then rd_req_a=1, rd_addr_a=3 for one edge -> the following cycle SHALL show rd_data_a=16'hBEEF and rd_valid_a=1, with rd_valid_a=0 one cycle after that.
REQ-031 The bench SHALL drive write=0, wr_addr=5, wr_data=16'h1234 and rd_req_b=1, rd_addr_b=5 on the same edge -> after that edge rd_data_b SHALL be 16'h1234 (bypass).
REQ-032 The bench SHALL drive write=0, wr_addr=7, wr_data=16'h00AA and pc_write=0, pc_in=16'h0055 on the same edge -> pc_out SHALL be 16'h00AA.
REQ-033 The bench SHALL drive pc_write=0, pc_in=16'h0010, then both ports reading R7 and R2 (R2 previously written 16'h0002) -> rd_data_a=16'h0010 and rd_data_b=16'h0002, both valid in the same cycle.
REQ-034 The bench SHALL load all registers, issue rd_req_a=1, then assert reset=0 at the next edge -> after that edge all rd outputs SHALL be 0 and a subsequent read of every address SHALL return 0.
REQ-035 The bench SHALL hold rd_req_a=1 for 4 edges cycling addresses 0..3 -> rd_valid_a SHALL be high for 4 consecutive cycles, with data following the address sequence with one-cycle latency.
